// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM encoding, master IDs
// and the data word returned on a timeout abort.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic M_IF = 1'b0;
  localparam logic M_LS = 1'b1;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_fair_sel.sv
// Fixed-priority pick favouring load/store, with a saturating starvation count
// that forces the fetch master through after STARVE_MAX consecutive losses.
module arb_fair_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en_i,
  input  logic m0_req_i,
  input  logic m1_req_i,
  output logic win_id_o,
  output logic win_valid_o
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       pick_m1;

  always_comb begin
    pick_m1      = m1_req_i & (~m0_req_i | (starve_cnt_q < SMAX));
    win_valid_o  = m0_req_i | m1_req_i;
    win_id_o     = pick_m1 ? M_LS : M_IF;
    starve_cnt_d = starve_cnt_q;
    if (arb_en_i && win_valid_o) begin
      // only a load/store win over a waiting fetch counts toward starvation
      if (pick_m1 && m0_req_i) begin
        starve_cnt_d = (starve_cnt_q == SMAX) ? SMAX : starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-ported memory, one transaction at a time.
// Optional abort on a stalled memory is enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate and latch the winner's request
// ADDR  | present request to memory until s_ready_i
// RESP  | wait for s_rvalid_i, then return data to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_i,
  input  logic [AW-1:0]   m0_addr_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_be_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            s_req_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  output logic [DW/8-1:0] s_be_o,
  input  logic            s_ready_i,
  input  logic            s_rvalid_i,
  input  logic [DW-1:0]   s_rdata_i,
  output logic            hold_flag_o,
  output logic            err_o
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYC at least 1");
  end

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   be_q, be_d;
  logic [DW-1:0]     m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic              arb_en, win_id, win_valid;

  arb_fair_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .clk         (clk),
    .rst         (rst),
    .arb_en_i    (arb_en),
    .m0_req_i    (m0_req_i),
    .m1_req_i    (m1_req_i),
    .win_id_o    (win_id),
    .win_valid_o (win_valid)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    arb_en      = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        if (win_valid) begin
          owner_d = win_id;
          state_d = ADDR;
          if (win_id == M_LS) begin
            addr_d  = m1_addr_i;
            we_d    = m1_we_i;
            wdata_d = m1_wdata_i;
            be_d    = m1_be_i;
          end else begin
            addr_d  = m0_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      ADDR: begin
        if (s_ready_i) state_d = RESP;
      end
      RESP: begin
        if (s_rvalid_i) begin
          state_d = IDLE;
          if (owner_q == M_LS) begin
            m1_rdata_d  = s_rdata_i;
            m1_rvalid_d = 1'b1;
          end else begin
            m0_rdata_d  = s_rdata_i;
            m0_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MEM_ARB_TIMEOUT_EN
    // down-counter reloads on every state change; terminal count means no progress
    err_d    = 1'b0;
    to_cnt_d = to_cnt_q;
    if ((state_q != IDLE) && (state_d == state_q) && (to_cnt_q == '0)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      if (owner_q == M_LS) begin
        m1_rdata_d  = DW'(ERR_RDATA);
        m1_rvalid_d = 1'b1;
      end else begin
        m0_rdata_d  = DW'(ERR_RDATA);
        m0_rvalid_d = 1'b1;
      end
    end
    if (state_d != state_q) begin
      to_cnt_d = TO_W'(TIMEOUT_CYC - 1);
    end else if (to_cnt_q != '0) begin
      to_cnt_d = to_cnt_q - TO_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= M_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign s_req_o     = (state_q == ADDR);
  assign s_we_o      = we_q;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_be_o      = be_q;
  assign m0_gnt_o    = s_req_o & s_ready_i & (owner_q == M_IF);
  assign m1_gnt_o    = s_req_o & s_ready_i & (owner_q == M_LS);
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign hold_flag_o = m0_req_i & ~m0_gnt_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small zero-wait memory responder whose
// ready/response can be withheld, and hand-computed expectations per step.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req, m1_we;
  logic [31:0] m0_addr, m1_addr, m1_wdata;
  logic [3:0]  m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ready, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        hold_flag, err;

  logic        ready_en, rvalid_en, rv_pend;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .m0_req_i    (m0_req),
    .m0_addr_i   (m0_addr),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_be_i     (m1_be),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .s_req_o     (s_req),
    .s_we_o      (s_we),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_be_o      (s_be),
    .s_ready_i   (s_ready),
    .s_rvalid_i  (s_rvalid),
    .s_rdata_i   (s_rdata),
    .hold_flag_o (hold_flag),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: accepts in the request cycle, answers the following cycle
  assign s_ready  = s_req & ready_en;
  assign s_rvalid = rv_pend & rvalid_en;
  assign s_rdata  = mem_rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv_pend <= 1'b0;
    else        rv_pend <= s_req & s_ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_order;
  logic       got, who;

  initial begin
    rst_n = 1'b0; m0_req = 0; m1_req = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    ready_en = 1'b1; rvalid_en = 1'b1; mem_rdata = '0;
    exp_order = 10'b1111011110;  // MSB first: m1 x4, m0, m1 x4, m0

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_s_req", s_req, 1'b0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    chk("rst_rdata", m0_rdata, 32'h0);
    chk("rst_hold", hold_flag, 1'b0);
    chk("rst_err", err, 1'b0);
    step(); rst_n = 1'b1;

    // m0 fetch, zero-wait memory
    step(); m0_req = 1; m0_addr = 32'h10; mem_rdata = 32'h13;
    @(negedge clk);
    chk("t1_hold_N", hold_flag, 1'b1);
    chk("t1_sreq_N", s_req, 1'b0);
    step(); @(negedge clk);
    chk("t1_sreq_N1", s_req, 1'b1);
    chk("t1_gnt_N1", m0_gnt, 1'b1);
    chk("t1_addr", s_addr, 32'h10);
    chk("t1_be_we", {s_be, s_we}, 5'b11110);
    step(); m0_req = 0; @(negedge clk);
    chk("t1_rvalid_N2", m0_rvalid, 1'b0);
    chk("t1_sreq_N2", s_req, 1'b0);
    step(); @(negedge clk);
    chk("t1_rvalid_N3", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("t1_rdata", m0_rdata, 32'h13);
    step(); @(negedge clk);
    chk("t1_rvalid_N4", m0_rvalid, 1'b0);
    chk("t1_rdata_hold", m0_rdata, 32'h13);

    // m1 write
    step(); m1_req = 1; m1_we = 1; m1_addr = 32'h100; m1_wdata = 32'hA5A5_5A5A;
    m1_be = 4'b0011; mem_rdata = 32'h77;
    step(); @(negedge clk);
    chk("t2_gnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("t2_we", s_we, 1'b1);
    chk("t2_be", s_be, 4'b0011);
    chk("t2_wdata", s_wdata, 32'hA5A5_5A5A);
    chk("t2_addr", s_addr, 32'h100);
    step(); m1_req = 0; m1_we = 0; @(negedge clk);
    chk("t2_rvalid_N2", m1_rvalid, 1'b0);
    step(); @(negedge clk);
    chk("t2_rvalid_N3", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("t2_m0_rdata_kept", m0_rdata, 32'h13);

    // both masters requesting continuously
    step(); m0_req = 1; m1_req = 1; m0_addr = 32'h200; m1_addr = 32'h300;
    for (int g = 0; g < 10; g++) begin
      got = 1'b0; who = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (m0_gnt || m1_gnt) begin
          got = 1'b1;
          who = m1_gnt;
          chk("t3_one_gnt", {m0_gnt, m1_gnt} == 2'b11, 1'b0);
        end
      end
      chk($sformatf("t3_order_%0d", g), {got, who}, {1'b1, exp_order[9-g]});
    end
    m0_req = 0; m1_req = 0;
    repeat (3) step();

    // memory stalls 5 cycles in ADDR
    ready_en = 1'b0; m0_req = 1; m0_addr = 32'h44; mem_rdata = 32'h55;
    for (int c = 0; c < 5; c++) begin
      step(); @(negedge clk);
      chk("t4_stall_req", s_req, 1'b1);
      chk("t4_stall_addr", s_addr, 32'h44);
      chk("t4_stall_gnt", m0_gnt, 1'b0);
      chk("t4_stall_hold", hold_flag, 1'b1);
    end
    step(); ready_en = 1'b1; @(negedge clk);
    chk("t4_gnt", m0_gnt, 1'b1);
    chk("t4_hold_gnt", hold_flag, 1'b0);
    step(); m0_req = 0; @(negedge clk);
    chk("t4_gnt_once", m0_gnt, 1'b0);
    step(); @(negedge clk);
    chk("t4_rvalid", m0_rvalid, 1'b1);
    chk("t4_rdata", m0_rdata, 32'h55);
    chk("t4_no_regnt", m0_gnt, 1'b0);

    // reset while waiting in RESP
    step(); rvalid_en = 1'b0; m0_req = 1; m0_addr = 32'h80;
    step(); @(negedge clk);
    chk("t5_gnt", m0_gnt, 1'b1);
    step(); m0_req = 0; @(negedge clk);
    chk("t5_in_resp", s_req, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sreq", s_req, 1'b0);
    chk("t5_rst_rdata", m0_rdata, 32'h0);
    step(); @(negedge clk);
    chk("t5_rst_rvalid", m0_rvalid, 1'b0);
    step(); rst_n = 1'b1; rvalid_en = 1'b1; @(negedge clk);
    chk("t5_post_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    step(); m0_req = 1; m0_addr = 32'h20; mem_rdata = 32'h99;
    step(); @(negedge clk);
    chk("t5_fresh_gnt", m0_gnt, 1'b1);
    chk("t5_fresh_addr", s_addr, 32'h20);
    step(); m0_req = 0;
    step(); @(negedge clk);
    chk("t5_fresh_rvalid", m0_rvalid, 1'b1);
    chk("t5_fresh_rdata", m0_rdata, 32'h99);

    // reset while presenting in ADDR drops s_req_o asynchronously
    step(); ready_en = 1'b0; m1_req = 1; m1_addr = 32'h300;
    step(); @(negedge clk);
    chk("t6_addr_req", s_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_drop", s_req, 1'b0);
    step(); rst_n = 1'b1; ready_en = 1'b1;
    step(); @(negedge clk);
    chk("t6_regnt", m1_gnt, 1'b1);
    step(); m1_req = 0;
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers: abort after 8 cycles in RESP
    step(); rvalid_en = 1'b0; m1_req = 1; m1_addr = 32'h400;
    step(); @(negedge clk);
    chk("to_gnt", m1_gnt, 1'b1);
    step(); m1_req = 0; @(negedge clk);
    chk("to_err_0", err, 1'b0);
    for (int c = 0; c < 7; c++) begin
      step(); @(negedge clk);
      chk("to_err_wait", {err, m1_rvalid}, 2'b00);
    end
    step(); @(negedge clk);
    chk("to_err", err, 1'b1);
    chk("to_rvalid", m1_rvalid, 1'b1);
    chk("to_rdata", m1_rdata, 32'hDEAD_BEEF);
    step(); @(negedge clk);
    chk("to_err_pulse", {err, m1_rvalid}, 2'b00);
    rvalid_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
